zbt_port_arbiter: RTL

- Shares the single ZBT SRAM port between two requesters:
  - the CPU mailbox path (register_control zbt_mbox_* signals), a four-phase single-access handshake;
  - the pixel pipeline (rasterizer/video), a request/grant stream of up to one access per cycle.
- Sits between register_control, the pixel datapath and the ZBT pin interface.
- Tracks outstanding accesses in a fixed-latency tag pipeline and routes read data back to the owner.

---
 rtl/zbt_port_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/zbt_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zbt_port_arbiter
// Purpose  : Shares the single ZBT SRAM port between the CPU mailbox
//            (four-phase single-access handshake) and the pixel pipeline
//            (request/grant stream, up to one access per cycle). Outstanding
//            accesses travel down a fixed-latency tag pipeline so that read
//            data and completions are routed back to their owner.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            mbox_*_i / mbox_*_o - mailbox handshake (sel/we/addr/wdata in,
//                                  dval/wdone/rdata out, outputs held)
//            pix_*_i / pix_*_o   - pixel stream (req/we/addr/wdata in,
//                                  combinational gnt, dval pulse, rdata out)
//            zbt_*               - ZBT pin interface (en, we_n, addr, wdata,
//                                  oe drive enable, rdata in)
// Revision : 1.0 - initial release
// ============================================================================
module zbt_port_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 36,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    // mailbox side
    input  logic              mbox_sel_i,
    input  logic              mbox_we_i,
    input  logic [ADDR_W-1:0] mbox_addr_i,
    input  logic [DATA_W-1:0] mbox_wdata_i,
    output logic              mbox_dval_o,
    output logic              mbox_wdone_o,
    output logic [DATA_W-1:0] mbox_rdata_o,
    // pixel side
    input  logic              pix_req_i,
    input  logic              pix_we_i,
    input  logic [ADDR_W-1:0] pix_addr_i,
    input  logic [DATA_W-1:0] pix_wdata_i,
    output logic              pix_gnt_o,
    output logic              pix_dval_o,
    output logic [DATA_W-1:0] pix_rdata_o,
    // ZBT pins
    output logic              zbt_en_o,
    output logic              zbt_we_n_o,
    output logic [ADDR_W-1:0] zbt_addr_o,
    output logic [DATA_W-1:0] zbt_wdata_o,
    output logic              zbt_oe_o,
    input  logic [DATA_W-1:0] zbt_rdata_i
);

    // Tag stage k holds the access whose address was on the pins k cycles
    // ago; stage READ_LAT is the data cycle of that access.
    localparam int c_DEPTH = READ_LAT + 1;

    localparam logic [1:0] c_M_IDLE  = 2'd0;
    localparam logic [1:0] c_M_ISSUE = 2'd1;
    localparam logic [1:0] c_M_WAIT  = 2'd2;
    localparam logic [1:0] c_M_DONE  = 2'd3;

    localparam logic c_OWN_PIX  = 1'b0;
    localparam logic c_OWN_MBOX = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_abort;
    logic              r_mbox_we;
    logic [DATA_W-1:0] r_mbox_rdata;

    logic              w_mbox_issue;
    logic              w_iss_v;
    logic              w_iss_we;
    logic [ADDR_W-1:0] w_iss_addr;
    logic [DATA_W-1:0] w_iss_wdata;

    logic              r_zbt_we_n;
    logic [ADDR_W-1:0] r_zbt_addr;
    logic [DATA_W-1:0] r_iss_wdata;
    logic [DATA_W-1:0] r_wdly [READ_LAT];

    logic [c_DEPTH-1:0] r_tag_v;
    logic [c_DEPTH-1:0] r_tag_we;
    logic [c_DEPTH-1:0] r_tag_own;

    logic              w_ret_v;
    logic              w_pix_ret;
    logic              w_mbox_ret;
    logic              r_pix_dval;
    logic [DATA_W-1:0] r_pix_rdata;

    // ------------------------------------------------------------------
    // Mailbox FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_M_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Mailbox FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_M_IDLE: begin
                if (mbox_sel_i) begin
                    w_state_nxt = c_M_ISSUE;
                end
            end
            c_M_ISSUE: begin
                w_state_nxt = c_M_WAIT;
            end
            c_M_WAIT: begin
                // An abandoned handshake still waits for its access to
                // drain, but never reports completion.
                if (w_mbox_ret) begin
                    if (r_abort || !mbox_sel_i) begin
                        w_state_nxt = c_M_IDLE;
                    end else begin
                        w_state_nxt = c_M_DONE;
                    end
                end
            end
            default: begin
                if (!mbox_sel_i) begin
                    w_state_nxt = c_M_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mailbox FSM: outputs and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_mbox_issue = (r_state == c_M_ISSUE);
        pix_gnt_o    = pix_req_i && !rst && !w_mbox_issue;
        mbox_dval_o  = (r_state == c_M_DONE) && !r_mbox_we;
        mbox_wdone_o = (r_state == c_M_DONE) && r_mbox_we;
    end

    // Remembers a sel drop during an access so that completion is
    // suppressed even if sel rises again before the data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort <= 1'b0;
        end else if (r_state == c_M_IDLE) begin
            r_abort <= 1'b0;
        end else if (((r_state == c_M_ISSUE) || (r_state == c_M_WAIT)) && !mbox_sel_i) begin
            r_abort <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mbox_we    <= 1'b0;
            r_mbox_rdata <= '0;
        end else begin
            if (w_mbox_issue) begin
                r_mbox_we <= mbox_we_i;
            end
            if ((r_state == c_M_WAIT) && w_mbox_ret && !r_tag_we[READ_LAT]) begin
                r_mbox_rdata <= zbt_rdata_i;
            end
        end
    end

    assign mbox_rdata_o = r_mbox_rdata;

    // ------------------------------------------------------------------
    // Issue mux: mailbox wins in its single issue cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_iss_v     = w_mbox_issue || pix_gnt_o;
        w_iss_we    = w_mbox_issue ? mbox_we_i    : pix_we_i;
        w_iss_addr  = w_mbox_issue ? mbox_addr_i  : pix_addr_i;
        w_iss_wdata = w_mbox_issue ? mbox_wdata_i : pix_wdata_i;
    end

    // Address phase registers and tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zbt_we_n  <= 1'b1;
            r_zbt_addr  <= '0;
            r_iss_wdata <= '0;
            r_tag_v     <= '0;
            r_tag_we    <= '0;
            r_tag_own   <= '0;
        end else begin
            r_zbt_we_n <= !(w_iss_v && w_iss_we);
            if (w_iss_v) begin
                r_zbt_addr  <= w_iss_addr;
                r_iss_wdata <= w_iss_wdata;
            end
            r_tag_v   <= {r_tag_v[c_DEPTH-2:0],   w_iss_v};
            r_tag_we  <= {r_tag_we[c_DEPTH-2:0],  w_iss_v && w_iss_we};
            r_tag_own <= {r_tag_own[c_DEPTH-2:0], w_mbox_issue ? c_OWN_MBOX : c_OWN_PIX};
        end
    end

    // Write data delay line: aligns write data with the data cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_wdly[i] <= '0;
            end
        end else begin
            r_wdly[0] <= r_iss_wdata;
            for (int i = 1; i < READ_LAT; i++) begin
                r_wdly[i] <= r_wdly[i-1];
            end
        end
    end

    assign zbt_en_o    = r_tag_v[0];
    assign zbt_we_n_o  = r_zbt_we_n;
    assign zbt_addr_o  = r_zbt_addr;
    assign zbt_wdata_o = r_wdly[READ_LAT-1];
    assign zbt_oe_o    = r_tag_v[READ_LAT] && r_tag_we[READ_LAT];

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    always_comb begin
        w_ret_v    = r_tag_v[READ_LAT];
        w_pix_ret  = w_ret_v && !r_tag_we[READ_LAT] && (r_tag_own[READ_LAT] == c_OWN_PIX);
        w_mbox_ret = w_ret_v && (r_tag_own[READ_LAT] == c_OWN_MBOX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_dval  <= 1'b0;
            r_pix_rdata <= '0;
        end else begin
            r_pix_dval <= w_pix_ret;
            if (w_pix_ret) begin
                r_pix_rdata <= zbt_rdata_i;
            end
        end
    end

    assign pix_dval_o  = r_pix_dval;
    assign pix_rdata_o = r_pix_rdata;

endmodule
`default_nettype wire
